// File: rtl/kmeans_k2d5_centroid_update_pkg.sv
// Shared types and constants for the k=2, 5-dimension centroid update block.
// Field index k*NUM_DIMS+d addresses both the accumulators and the packed centroid buses.
package kmeans_pkg;
    localparam int NUM_CENTROIDS = 2;
    localparam int NUM_DIMS      = 5;
    localparam int NUM_FIELDS    = NUM_CENTROIDS * NUM_DIMS;
    localparam int IDX_W         = 4;

    localparam int DEF_W  = 8;
    localparam int DEF_N  = 8;
    localparam int DEF_SW = DEF_W + DEF_N + 1;
    localparam int DEF_CW = DEF_N + 1;

    localparam logic [IDX_W-1:0] FIRST_K1_IDX = IDX_W'(NUM_DIMS);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_FIELDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DIV_LOAD,
        S_DIV_RUN,
        S_DONE
    } state_t;

    function automatic int field_lsb(input logic [IDX_W-1:0] idx, input int w);
        return int'(idx) * w;
    endfunction
endpackage

// File: rtl/kmeans_k2d5_centroid_update_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, SW cycles after start.
// done pulses on the final step; quotient is valid in that same cycle.
module kmeans_seq_divider #(
    parameter int SW = 17,
    parameter int CW = 9,
    parameter int QW = SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int STW = $clog2(SW + 1);

    logic [SW-1:0]  quo_q;
    logic [CW:0]    rem_q;
    logic [CW-1:0]  dvs_q;
    logic [STW-1:0] step_q;
    logic           run_q;

    logic [CW+1:0]  trial;
    logic [CW+1:0]  diff;
    logic           ge;
    logic [SW-1:0]  quo_nxt;

    // The spare remainder bit keeps every bit of trial/diff meaningful.
    assign trial   = {rem_q, quo_q[SW-1]};
    assign diff    = trial - {2'b00, dvs_q};
    assign ge      = trial >= {2'b00, dvs_q};
    assign quo_nxt = {quo_q[SW-2:0], ge};

    assign done     = run_q && (step_q == STW'(1));
    assign quotient = quo_nxt[QW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            step_q <= STW'(SW);
            run_q  <= 1'b1;
        end else if (run_q) begin
            quo_q  <= quo_nxt;
            rem_q  <= ge ? diff[CW:0] : trial[CW:0];
            step_q <= step_q - STW'(1);
            if (step_q == STW'(1))
                run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/kmeans_k2d5_centroid_update.sv
// Accumulates per-centroid sums/counts over a pass, then divides to form new centroids.
// Optional KMEANS_CENTROID_ROUND_EN: round-half-up mean instead of truncation.
module kmeans_k2d5_centroid_update
    import kmeans_pkg::*;
#(
    parameter int input_data_width         = DEF_W,
    parameter int input_data_qty_bit_width = DEF_N,
    parameter int sum_width                = input_data_width + input_data_qty_bit_width + 1,
    parameter int cnt_width                = input_data_qty_bit_width + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic                             in_sel,
    input  logic [input_data_width-1:0]      in_d0,
    input  logic [input_data_width-1:0]      in_d1,
    input  logic [input_data_width-1:0]      in_d2,
    input  logic [input_data_width-1:0]      in_d3,
    input  logic [input_data_width-1:0]      in_d4,
    input  logic [NUM_FIELDS*input_data_width-1:0] old_k,
    output logic [NUM_FIELDS*input_data_width-1:0] new_k,
    output logic                             busy,
    output logic                             done
);
    localparam int W  = input_data_width;
    localparam int SW = sum_width;
    localparam int CW = cnt_width;

    state_t           state_q, state_d;
    logic [SW-1:0]    sum_q [NUM_FIELDS];
    logic [CW-1:0]    cnt_q [NUM_CENTROIDS];
    logic [IDX_W-1:0] idx_q;
    logic             done_q;

    logic [W-1:0]     din [NUM_DIMS];
    logic             cur_k;
    logic [CW-1:0]    cur_cnt;
    logic [SW-1:0]    div_dividend;
    logic             div_start;
    logic             div_done;
    logic [W-1:0]     div_quo;

    assign din[0] = in_d0;
    assign din[1] = in_d1;
    assign din[2] = in_d2;
    assign din[3] = in_d3;
    assign din[4] = in_d4;

    assign cur_k   = (idx_q >= FIRST_K1_IDX);
    assign cur_cnt = cnt_q[cur_k];

`ifdef KMEANS_CENTROID_ROUND_EN
    assign div_dividend = sum_q[idx_q] + SW'(cur_cnt >> 1);
`else
    assign div_dividend = sum_q[idx_q];
`endif

    kmeans_seq_divider #(
        .SW (SW),
        .CW (CW),
        .QW (W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (cur_cnt),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE:     if (start) state_d = S_ACC;
            S_ACC:      if (in_valid && in_last) state_d = S_DIV_LOAD;
            S_DIV_LOAD: begin
                div_start = 1'b1;
                state_d   = S_DIV_RUN;
            end
            S_DIV_RUN:  if (div_done) state_d = (idx_q == LAST_IDX) ? S_DONE : S_DIV_LOAD;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_ACC) || (state_q == S_DIV_LOAD) || (state_q == S_DIV_RUN);
    assign done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            new_k   <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) sum_q[i] <= '0;
            for (int k = 0; k < NUM_CENTROIDS; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            // Registered so done lands one cycle after the DONE state is entered.
            done_q  <= (state_q == S_DONE);
            if (state_q == S_IDLE && start) begin
                idx_q <= '0;
                for (int i = 0; i < NUM_FIELDS; i++) sum_q[i] <= '0;
                for (int k = 0; k < NUM_CENTROIDS; k++) cnt_q[k] <= '0;
            end else if (state_q == S_ACC && in_valid) begin
                for (int d = 0; d < NUM_DIMS; d++)
                    sum_q[int'(in_sel)*NUM_DIMS + d] <= sum_q[int'(in_sel)*NUM_DIMS + d] + SW'(din[d]);
                cnt_q[in_sel] <= cnt_q[in_sel] + CW'(1);
            end
            if (state_q == S_DIV_RUN && div_done) begin
                // Empty cluster keeps its previous centroid; divider still runs for fixed latency.
                if (cur_cnt == '0)
                    new_k[field_lsb(idx_q, W) +: W] <= old_k[field_lsb(idx_q, W) +: W];
                else
                    new_k[field_lsb(idx_q, W) +: W] <= div_quo;
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end
endmodule
